// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_divider_pkg;

    // Controller states: waiting for a request, or iterating one quotient bit per clock.
    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Width of the iteration counter, which must hold values 0 .. size-1.
    function automatic int cnt_width(input int size);
        int w;
        w = $clog2(size);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration: shift the next dividend bit into
// the partial remainder, try to subtract the divisor, keep the difference if it
// did not go negative.
module divider_step #(
    parameter int SIZE = 8
) (
    input  logic [SIZE:0]   rem,
    input  logic            quo_msb,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE:0]   next_rem,
    output logic            q_bit
);

    logic [SIZE+1:0] shifted;
    logic [SIZE+1:0] trial;

    // Trial subtraction carried one bit wider than the remainder so its sign bit is exact.
    always_comb begin
        shifted = {rem, quo_msb};
        trial   = shifted - {2'b00, divisor};
        if (trial[SIZE+1] == 1'b0) begin
            next_rem = trial[SIZE:0];
            q_bit    = 1'b1;
        end else begin
            next_rem = shifted[SIZE:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider with a start/busy/done handshake.
// One quotient bit is produced per clock; results are published on the edge that
// finishes the last iteration and held until the next division completes.
// Optional macro SEQ_DIVIDER_ZERO_BYPASS_EN: a zero divisor finishes immediately
// (done one cycle after the start edge, busy never raised) with the same results
// the full iteration would produce.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] q,
    output logic [SIZE-1:0] r,
    output logic            div_by_zero
);

    localparam int CW = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE:0]   rem_q, rem_d;
    logic [SIZE-1:0] quo_q, quo_d;
    logic [SIZE-1:0] dvs_q, dvs_d;
    logic            zero_q, zero_d;
    logic [SIZE-1:0] q_res_q, q_res_d;
    logic [SIZE-1:0] r_res_q, r_res_d;
    logic            dbz_q, dbz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [SIZE:0]   step_rem;
    logic            step_bit;
    logic [SIZE-1:0] quo_next;

    // The single iteration datapath, reused every CALC cycle.
    divider_step #(.SIZE(SIZE)) u_step (
        .rem      (rem_q),
        .quo_msb  (quo_q[SIZE-1]),
        .divisor  (dvs_q),
        .next_rem (step_rem),
        .q_bit    (step_bit)
    );

    assign quo_next = {quo_q[SIZE-2:0], step_bit};

    // Next-state logic for the controller, working registers and published results.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        q_res_d = q_res_q;
        r_res_d = r_res_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
                    if (b == '0) begin
                        done_d  = 1'b1;
                        q_res_d = '1;
                        r_res_d = a;
                        dbz_d   = 1'b1;
                    end else begin
                        quo_d   = a;
                        rem_d   = '0;
                        dvs_d   = b;
                        cnt_d   = '0;
                        zero_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
`else
                    quo_d   = a;
                    rem_d   = '0;
                    dvs_d   = b;
                    cnt_d   = '0;
                    zero_d  = (b == '0);
                    busy_d  = 1'b1;
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = quo_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_res_d = quo_next;
                    r_res_d = step_rem[SIZE-1:0];
                    dbz_d   = zero_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state registers; reset discards any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            zero_q  <= 1'b0;
            q_res_q <= '0;
            r_res_q <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            q_res_q <= q_res_d;
            r_res_q <= r_res_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign q           = q_res_q;
    assign r           = r_res_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (SIZE=8) against an arithmetic reference model.
module tb_seq_divider;

    localparam int SIZE = 8;
    localparam int LAT  = SIZE + 1;
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = SIZE + 1;
    localparam int ZBUSY = SIZE;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SIZE-1:0] a = '0;
    logic [SIZE-1:0] b = '0;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference model: plain integer division, zero divisor gives all ones and the dividend.
    function automatic void ref_div(input int av, input int bv,
                                    output int qv, output int rv, output bit zv);
        if (bv == 0) begin
            qv = (1 << SIZE) - 1;
            rv = av;
            zv = 1'b1;
        end else begin
            qv = av / bv;
            rv = av % bv;
            zv = 1'b0;
        end
    endfunction

    // Pulse start for one clock; returns at the falling edge right after the accepting edge.
    task automatic apply_stimulus(input int av, input int bv);
        @(negedge clk);
        a     = SIZE'(av);
        b     = SIZE'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; lat counts edges from the accepting edge, inclusive.
    task automatic wait_done(output bit seen, output int lat, output int busy_cnt,
                             output bit overlap);
        seen = 1'b0; lat = 0; busy_cnt = 0; overlap = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy && done) overlap = 1'b1;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = k + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({busy, done, q, r, div_by_zero} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
                     busy, done, q, r, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        bit seen, ov; int lat, bc;
        apply_stimulus(100, 7);
        wait_done(seen, lat, bc, ov);
        checks++;
        if (!seen || lat != LAT || bc != SIZE || ov) begin
            errors++;
            $display("[TB] FAIL basic_timing got seen=%b lat=%0d busy=%0d overlap=%b want 1 %0d %0d 0",
                     seen, lat, bc, ov, LAT, SIZE);
        end
        checks++;
        if (q !== 8'd14 || r !== 8'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result got q=%0d r=%0d dbz=%b want 14 2 0", q, r, div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || q !== 8'd14 || r !== 8'd2) begin
            errors++;
            $display("[TB] FAIL basic_after got done=%b q=%0d r=%0d want 0 14 2", done, q, r);
        end
    endtask

    task automatic test_patterns;
        int ta[3] = '{255, 5, 0};
        int tb[3] = '{1, 9, 3};
        bit seen, ov, ez; int lat, bc, eq, er;
        for (int i = 0; i < 3; i++) begin
            ref_div(ta[i], tb[i], eq, er, ez);
            apply_stimulus(ta[i], tb[i]);
            wait_done(seen, lat, bc, ov);
            checks++;
            if (!seen || int'(q) != eq || int'(r) != er || div_by_zero !== ez) begin
                errors++;
                $display("[TB] FAIL pattern_%0d got seen=%b q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                         i, seen, q, r, div_by_zero, eq, er, ez);
            end
        end
    endtask

    task automatic test_div_zero;
        bit seen, ov; int lat, bc;
        apply_stimulus(200, 0);
        wait_done(seen, lat, bc, ov);
        checks++;
        if (!seen || lat != ZLAT || bc != ZBUSY || ov) begin
            errors++;
            $display("[TB] FAIL zero_timing got seen=%b lat=%0d busy=%0d overlap=%b want 1 %0d %0d 0",
                     seen, lat, bc, ov, ZLAT, ZBUSY);
        end
        checks++;
        if (q !== 8'd255 || r !== 8'd200 || div_by_zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_result got q=%0d r=%0d dbz=%b want 255 200 1", q, r, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        bit seen, ov; int lat, bc;
        apply_stimulus(100, 7);
        @(negedge clk);
        @(negedge clk);
        a = 8'd50; b = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen, lat, bc, ov);
        checks++;
        if (!seen || q !== 8'd14 || r !== 8'd2) begin
            errors++;
            $display("[TB] FAIL ignored_start got seen=%b q=%0d r=%0d want 1 14 2", seen, q, r);
        end
        // Request again during the done cycle; it must be accepted.
        a = 8'd50; b = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 8'd14 || r !== 8'd2) begin
            errors++;
            $display("[TB] FAIL done_cycle_accept got busy=%b done=%b q=%0d r=%0d want 1 0 14 2",
                     busy, done, q, r);
        end
        wait_done(seen, lat, bc, ov);
        checks++;
        if (!seen || lat != LAT || q !== 8'd10 || r !== 8'd0) begin
            errors++;
            $display("[TB] FAIL back_to_back got seen=%b lat=%0d q=%0d r=%0d want 1 %0d 10 0",
                     seen, lat, q, r, LAT);
        end
    endtask

    task automatic test_reset_mid;
        bit seen, ov, spurious; int lat, bc;
        apply_stimulus(100, 7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, q, r, div_by_zero} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
                     busy, done, q, r, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int k = 0; k < SIZE + 4; k++) begin
            @(negedge clk);
            if (done || busy) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("[TB] FAIL no_done_after_reset got activity=1 want 0");
        end
        apply_stimulus(77, 6);
        wait_done(seen, lat, bc, ov);
        checks++;
        if (!seen || lat != LAT || q !== 8'd12 || r !== 8'd5 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset got seen=%b lat=%0d q=%0d r=%0d dbz=%b want 1 %0d 12 5 0",
                     seen, lat, q, r, div_by_zero, LAT);
        end
    endtask

    task automatic test_random;
        bit seen, ov, ez; int lat, bc, eq, er, av, bv;
        for (int i = 0; i < 1000; i++) begin
            av = int'($urandom_range(0, 255));
            bv = int'($urandom_range(1, 255));
            ref_div(av, bv, eq, er, ez);
            apply_stimulus(av, bv);
            wait_done(seen, lat, bc, ov);
            checks++;
            if (!seen || int'(q) != eq || int'(r) != er || div_by_zero !== ez || lat != LAT) begin
                errors++;
                $display("[TB] FAIL random_%0d a=%0d b=%0d got seen=%b lat=%0d q=%0d r=%0d want q=%0d r=%0d",
                         i, av, bv, seen, lat, q, r, eq, er);
            end
            checks++;
            if (int'(q) * bv + int'(r) != av || int'(r) >= bv) begin
                errors++;
                $display("[TB] FAIL random_invariant_%0d a=%0d b=%0d got q=%0d r=%0d", i, av, bv, q, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
